// File: rtl/fft_frame_unloader.sv
// fft_frame_unloader: captures whole FFT frames into a ping-pong buffer and
// streams bins out one per beat in natural order over valid/ready.
// Frames arriving with both buffers full are dropped and counted.
module fft_frame_unloader #(
  parameter int DATA_WIDTH = 11,
  parameter int POW        = 3,
  parameter int CNT_WIDTH  = 8,
  localparam int OW        = DATA_WIDTH + 2*POW,
  localparam int N         = 2**POW
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N*OW-1:0]      frame_r,
  input  logic [N*OW-1:0]      frame_i,
  input  logic                 frame_valid,
  output logic [OW-1:0]        src_r,
  output logic [OW-1:0]        src_i,
  output logic [POW-1:0]       src_idx,
  output logic                 src_sop,
  output logic                 src_eop,
  output logic                 src_valid,
  input  logic                 src_ready,
  output logic                 overflow,
  output logic [CNT_WIDTH-1:0] drop_cnt
);

  typedef enum logic {IDLE = 1'b0, STREAM = 1'b1} state_t;

  state_t         state, state_nxt;
  logic [OW-1:0]  buf_r [2][N];
  logic [OW-1:0]  buf_i [2][N];
  logic [1:0]     full, full_nxt;
  logic           wsel, rsel, rsel_nxt;
  logic [POW-1:0] idx, idx_nxt;
  logic           xfer, last, cap, drop;

  // Handshake, capture/drop decision and next-state of the read side.
  // A capture into the buffer being released on the same edge is allowed:
  // the clear of the old frame is applied before the set of the new one.
  always_comb begin
    xfer      = (state == STREAM) && src_ready;
    last      = xfer && (idx == POW'(N-1));
    cap       = frame_valid && (!full[wsel] || (last && (rsel == wsel)));
    drop      = frame_valid && !cap;
    full_nxt  = full;
    if (last) full_nxt[rsel] = 1'b0;
    if (cap)  full_nxt[wsel] = 1'b1;
    rsel_nxt  = rsel ^ last;
    idx_nxt   = idx;
    if (xfer) idx_nxt = last ? '0 : idx + 1'b1;
    // Looking at the next-cycle full flag gives one-cycle capture latency
    // and a bubble-free hand-over to the other buffer.
    state_nxt = full_nxt[rsel_nxt] ? STREAM : IDLE;
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Buffer pointers, full flags, read index and drop statistics.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full     <= '0;
      wsel     <= 1'b0;
      rsel     <= 1'b0;
      idx      <= '0;
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else begin
      full     <= full_nxt;
      rsel     <= rsel_nxt;
      idx      <= idx_nxt;
      overflow <= drop;
      if (cap) wsel <= ~wsel;
      if (drop && (drop_cnt != '1)) drop_cnt <= drop_cnt + 1'b1;
    end
  end

  // Frame storage: the whole frame is written in one cycle on capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int b = 0; b < 2; b++)
        for (int k = 0; k < N; k++) begin
          buf_r[b][k] <= '0;
          buf_i[b][k] <= '0;
        end
    end else if (cap) begin
      for (int k = 0; k < N; k++) begin
        buf_r[wsel][k] <= frame_r[k*OW +: OW];
        buf_i[wsel][k] <= frame_i[k*OW +: OW];
      end
    end
  end

  // Outputs decode registered state only; data is gated to zero when idle.
  assign src_valid = (state == STREAM);
  assign src_idx   = idx;
  assign src_sop   = src_valid && (idx == '0);
  assign src_eop   = src_valid && (idx == POW'(N-1));
  assign src_r     = src_valid ? buf_r[rsel][idx] : '0;
  assign src_i     = src_valid ? buf_i[rsel][idx] : '0;

endmodule

// File: tb/tb_fft_frame_unloader.sv
// Directed bench for fft_frame_unloader. Frame "id" carries bins
// r[k] = id*16+k and i[k] = -(id*16+k), so every beat is self-identifying.
module tb_fft_frame_unloader;

  localparam int DATA_WIDTH = 11;
  localparam int POW        = 3;
  localparam int CNT_WIDTH  = 8;
  localparam int OW         = DATA_WIDTH + 2*POW;
  localparam int N          = 2**POW;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic [N*OW-1:0]      frame_r, frame_i;
  logic                 frame_valid;
  logic [OW-1:0]        src_r, src_i;
  logic [POW-1:0]       src_idx;
  logic                 src_sop, src_eop, src_valid, src_ready;
  logic                 overflow;
  logic [CNT_WIDTH-1:0] drop_cnt;

  int nchk = 0;
  int nerr = 0;

  fft_frame_unloader #(.DATA_WIDTH(DATA_WIDTH), .POW(POW), .CNT_WIDTH(CNT_WIDTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .frame_r(frame_r), .frame_i(frame_i), .frame_valid(frame_valid),
    .src_r(src_r), .src_i(src_i), .src_idx(src_idx),
    .src_sop(src_sop), .src_eop(src_eop), .src_valid(src_valid),
    .src_ready(src_ready), .overflow(overflow), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_frame(input int id);
    logic [OW-1:0] v;
    for (int k = 0; k < N; k++) begin
      v = OW'(id*16 + k);
      frame_r[k*OW +: OW] = v;
      frame_i[k*OW +: OW] = -v;
    end
  endtask

  task automatic send(input int id);
    set_frame(id);
    frame_valid = 1'b1;
    tick();
    frame_valid = 1'b0;
  endtask

  task automatic chk_beat(input int id, input int k);
    logic [OW-1:0] er, ei;
    er = OW'(id*16 + k);
    ei = -er;
    chk("valid", 32'(src_valid), 32'd1);
    chk("src_r", 32'(src_r), 32'(er));
    chk("src_i", 32'(src_i), 32'(ei));
    chk("idx",   32'(src_idx), 32'(k));
    chk("sop",   32'(src_sop), 32'(k == 0));
    chk("eop",   32'(src_eop), 32'(k == N-1));
  endtask

  // Consume nfr frames (ids id0 then id1); bp selects ready pattern 1,0,0.
  // src_valid is required every cycle until the last frame's eop.
  task automatic drain(input int nfr, input int id0, input int id1, input bit bp);
    int k = 0, f = 0, cyc = 0;
    while (f < nfr && cyc < 400) begin
      src_ready = bp ? (cyc % 3 == 0) : 1'b1;
      chk_beat((f == 0) ? id0 : id1, k);
      if (src_ready) begin
        if (k == N-1) begin k = 0; f++; end
        else k++;
      end
      tick();
      cyc++;
    end
    if (cyc >= 400) chk("drain_timeout", 32'd0, 32'd1);
    chk("idle_after", 32'(src_valid), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; frame_valid = 1'b0; src_ready = 1'b0;
    frame_r = '0; frame_i = '0;
    tick(); tick();
    chk("rst_valid", 32'(src_valid), 32'd0);
    chk("rst_r",     32'(src_r), 32'd0);
    chk("rst_sop",   32'(src_sop), 32'd0);
    chk("rst_ovf",   32'(overflow), 32'd0);
    chk("rst_cnt",   32'(drop_cnt), 32'd0);
    rst_n = 1'b1;
    tick();

    // 1: single frame, ready high, beat 0 visible the cycle after capture
    send(0);
    drain(1, 0, 0, 1'b0);

    // 2: backpressure 1,0,0 pattern
    send(1);
    drain(1, 1, 0, 1'b1);

    // 3: two frames on consecutive edges, no gap between them
    src_ready = 1'b0;
    send(2);
    send(3);
    drain(2, 2, 3, 1'b0);
    chk("t3_ovf", 32'(overflow), 32'd0);
    chk("t3_cnt", 32'(drop_cnt), 32'd0);

    // 4: three frames with ready low, third dropped
    src_ready = 1'b0;
    send(4); chk("t4_ovf1", 32'(overflow), 32'd0);
    send(5); chk("t4_ovf2", 32'(overflow), 32'd0);
    send(6); chk("t4_ovf3", 32'(overflow), 32'd1);
    chk("t4_cnt", 32'(drop_cnt), 32'd1);
    tick();
    chk("t4_ovf4", 32'(overflow), 32'd0);
    drain(2, 4, 5, 1'b0);

    // 5: both full, new frame on the edge of the read buffer's last beat
    src_ready = 1'b0;
    send(7);
    send(8);
    src_ready = 1'b1;
    for (int k = 0; k < N-1; k++) begin
      chk_beat(7, k);
      tick();
    end
    chk_beat(7, N-1);
    set_frame(9);
    frame_valid = 1'b1;
    tick();
    frame_valid = 1'b0;
    chk("t5_ovf", 32'(overflow), 32'd0);
    chk("t5_cnt", 32'(drop_cnt), 32'd1);
    drain(2, 8, 9, 1'b0);

    // 6: async reset at beat 3 with a second frame buffered
    src_ready = 1'b0;
    send(10);
    send(11);
    src_ready = 1'b1;
    tick(); tick(); tick();
    chk_beat(10, 3);
    rst_n = 1'b0;
    #1;
    chk("r6_valid", 32'(src_valid), 32'd0);
    chk("r6_r",     32'(src_r), 32'd0);
    chk("r6_i",     32'(src_i), 32'd0);
    chk("r6_idx",   32'(src_idx), 32'd0);
    chk("r6_sop",   32'(src_sop), 32'd0);
    chk("r6_eop",   32'(src_eop), 32'd0);
    chk("r6_cnt",   32'(drop_cnt), 32'd0);
    tick(); tick();
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      chk("r6_quiet", 32'(src_valid), 32'd0);
    end
    send(12);
    drain(1, 12, 12, 1'b0);

    // drop counter saturation
    src_ready = 1'b0;
    send(20);
    send(21);
    set_frame(22);
    frame_valid = 1'b1;
    for (int i = 0; i < 300; i++) begin
      tick();
      if (i == 0)  chk("sat_ovf", 32'(overflow), 32'd1);
      if (i == 99) chk("sat_100", 32'(drop_cnt), 32'd100);
    end
    frame_valid = 1'b0;
    chk("sat_cnt", 32'(drop_cnt), 32'd255);
    tick();
    chk("sat_ovf_end", 32'(overflow), 32'd0);
    chk("sat_hold", 32'(drop_cnt), 32'd255);
    drain(2, 20, 21, 1'b0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
